// File: rtl/ov7670_cfg_seq.sv
// OV7670 register-init sequencer: walks a ROM of {reg,data} words and issues SCCB writes.
// Optional OV7670_CFG_RETRY_EN retries a NACKed write up to three times before flagging an error.
module ov7670_cfg_seq #(
    parameter int         DEPTH        = 101,
    parameter int         LEN          = $clog2(DEPTH),
    parameter int         DELAY_CYCLES = 1000000,
    parameter logic [7:0] SCCB_ID      = 8'h42
) (
    input  logic           i_cfg_clk,
    input  logic           i_cfg_rstn,
    input  logic           i_cfg_start,
    output logic           o_cfg_rom_rden,
    output logic [LEN-1:0] o_cfg_rom_addr,
    input  logic [15:0]    i_cfg_rom_data,
    output logic           o_cfg_sccb_valid,
    input  logic           i_cfg_sccb_ready,
    output logic [7:0]     o_cfg_sccb_id,
    output logic [7:0]     o_cfg_sccb_reg,
    output logic [7:0]     o_cfg_sccb_data,
    input  logic           i_cfg_sccb_done,
    input  logic           i_cfg_sccb_nack,
    output logic           o_cfg_busy,
    output logic           o_cfg_done,
    output logic           o_cfg_err
);

    typedef enum logic [3:0] {
        IDLE, FETCH, ROMWAIT, DECODE, SEND, WAITDONE, DELAY, NEXT, FINISH
    } state_t;

    localparam logic [LEN-1:0] LAST_ADDR  = LEN'(DEPTH - 1);
    localparam logic [31:0]    DELAY_LAST = 32'(DELAY_CYCLES - 1);

    state_t         state, state_next;
    logic [LEN-1:0] addr;
    logic [7:0]     reg_q, data_q;
    logic [31:0]    delay_cnt;
    logic           err_q;
    logic           retry_ok;
    logic           is_last, delay_last;

`ifdef OV7670_CFG_RETRY_EN
    logic [1:0] retries;
    assign retry_ok = (retries != 2'd3);
`else
    assign retry_ok = 1'b0;
`endif

    assign is_last    = (addr == LAST_ADDR);
    assign delay_last = (delay_cnt == DELAY_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (i_cfg_start) state_next = FETCH;
            FETCH:    state_next = ROMWAIT;
            ROMWAIT:  state_next = DECODE;
            DECODE: begin
                if (i_cfg_rom_data == 16'hFFFF)      state_next = FINISH;
                else if (i_cfg_rom_data == 16'hFFF0) state_next = DELAY;
                else                                 state_next = SEND;
            end
            SEND:     if (i_cfg_sccb_ready) state_next = WAITDONE;
            WAITDONE: begin
                if (i_cfg_sccb_done)
                    state_next = (i_cfg_sccb_nack && retry_ok) ? SEND : NEXT;
            end
            DELAY:    if (delay_last) state_next = NEXT;
            NEXT:     state_next = is_last ? FINISH : FETCH;
            FINISH:   if (i_cfg_start) state_next = FETCH;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_cfg_clk or negedge i_cfg_rstn) begin
        if (!i_cfg_rstn) state <= IDLE;
        else             state <= state_next;
    end

    always_ff @(posedge i_cfg_clk or negedge i_cfg_rstn) begin
        if (!i_cfg_rstn) begin
            addr      <= '0;
            reg_q     <= '0;
            data_q    <= '0;
            delay_cnt <= '0;
            err_q     <= 1'b0;
`ifdef OV7670_CFG_RETRY_EN
            retries   <= '0;
`endif
        end else begin
            case (state)
                IDLE, FINISH: begin
                    if (i_cfg_start) begin
                        addr  <= '0;
                        err_q <= 1'b0;
                    end
                end
                DECODE: begin
                    if (i_cfg_rom_data != 16'hFFFF && i_cfg_rom_data != 16'hFFF0) begin
                        reg_q  <= i_cfg_rom_data[15:8];
                        data_q <= i_cfg_rom_data[7:0];
`ifdef OV7670_CFG_RETRY_EN
                        retries <= '0;
`endif
                    end
                end
                WAITDONE: begin
                    if (i_cfg_sccb_done && i_cfg_sccb_nack) begin
`ifdef OV7670_CFG_RETRY_EN
                        if (retry_ok) retries <= retries + 2'd1;
                        else          err_q   <= 1'b1;
`else
                        err_q <= 1'b1;
`endif
                    end
                end
                DELAY:   delay_cnt <= delay_last ? '0 : delay_cnt + 32'd1;
                // The address parks on the final entry so it never wraps when DEPTH is a power of two.
                NEXT:    if (!is_last) addr <= addr + 1'b1;
                default: ;
            endcase
        end
    end

    assign o_cfg_rom_rden   = (state == FETCH);
    assign o_cfg_rom_addr   = addr;
    assign o_cfg_sccb_valid = (state == SEND);
    assign o_cfg_sccb_id    = SCCB_ID;
    assign o_cfg_sccb_reg   = reg_q;
    assign o_cfg_sccb_data  = data_q;
    assign o_cfg_busy       = (state != IDLE) && (state != FINISH);
    assign o_cfg_done       = (state == FINISH);
    assign o_cfg_err        = err_q;

endmodule

// File: tb/tb_ov7670_cfg_seq.sv
// Self-checking bench for ov7670_cfg_seq: ROM and SCCB slave models plus a pass-level reference model.
module tb_ov7670_cfg_seq;

    localparam int DEPTH = 4;
    localparam int LEN   = 2;
    localparam int DLY   = 20;

`ifdef OV7670_CFG_RETRY_EN
    localparam int MAXTRY = 4;
`else
    localparam int MAXTRY = 1;
`endif

    logic           clk = 1'b0;
    logic           rstn, start, rden, valid, ready, sdone, nack, busy, done, err;
    logic [LEN-1:0] raddr;
    logic [15:0]    rdata;
    logic [7:0]     id, rg, dt;

    always #5 clk = ~clk;

    ov7670_cfg_seq #(
        .DEPTH(DEPTH), .LEN(LEN), .DELAY_CYCLES(DLY), .SCCB_ID(8'h42)
    ) dut (
        .i_cfg_clk(clk), .i_cfg_rstn(rstn), .i_cfg_start(start),
        .o_cfg_rom_rden(rden), .o_cfg_rom_addr(raddr), .i_cfg_rom_data(rdata),
        .o_cfg_sccb_valid(valid), .i_cfg_sccb_ready(ready),
        .o_cfg_sccb_id(id), .o_cfg_sccb_reg(rg), .o_cfg_sccb_data(dt),
        .i_cfg_sccb_done(sdone), .i_cfg_sccb_nack(nack),
        .o_cfg_busy(busy), .o_cfg_done(done), .o_cfg_err(err)
    );

    logic [15:0] rom [DEPTH];
    always @(posedge clk) if (rden) rdata <= rom[raddr];

    int compared = 0, mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SCCB slave model: ready after ready_wait cycles of valid, done/nack lat cycles after accept.
    int          ready_wait = 0, wait_cnt = 0, lat = 3, pend = 0, nack_word = -1;
    int          unstable = 0, low_ready = 0, fetches = 0, id_bad = 0;
    logic        pend_nack = 1'b0;
    logic [15:0] hold = '0;
    bit          stray = 0;
    bit          nack_q[$];
    bit          plan[$];
    logic [15:0] obs_q[$];

    always @(negedge clk) begin
        sdone = 1'b0;
        nack  = 1'b0;
        if (!rstn) begin
            pend = 0; wait_cnt = 0; ready = 1'b0;
        end else begin
            if (rden) fetches++;
            if (stray) begin sdone = 1'b1; stray = 0; end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin sdone = 1'b1; nack = pend_nack; end
            end
            if (valid) begin
                if (id !== 8'h42) id_bad++;
                if (wait_cnt == 0) hold = {rg, dt};
                else if ({rg, dt} !== hold) unstable++;
                ready = (wait_cnt >= ready_wait);
                if (ready) begin
                    obs_q.push_back({rg, dt});
                    pend      = lat;
                    pend_nack = (nack_word == int'({rg, dt}));
                    if (nack_q.size() > 0) pend_nack = pend_nack | nack_q.pop_front();
                    wait_cnt  = 0;
                end else begin
                    low_ready++;
                    wait_cnt++;
                end
            end else begin
                ready = 1'b0; wait_cnt = 0;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // One complete pass: reference model derived from ROM contents, then observe and compare.
    task automatic run_pass(input string tag, input int rw, input int dl, input int nw,
                            input bit stray_en, input bit extra_start);
        logic [15:0] exp_w[$];
        bit          exp_err = 0, has_write = 0, ok;
        int          exp_fetch = 0, ni = 0, lead = 0, first = -1, c = 0;
        bit          n;

        for (int a = 0; a < DEPTH; a++) begin
            exp_fetch++;
            if (rom[a] == 16'hFFFF) break;
            if (rom[a] == 16'hFFF0) continue;
            ok = 0;
            for (int t = 0; t < MAXTRY; t++) begin
                exp_w.push_back(rom[a]);
                n = (nw == int'(rom[a])) || (ni < plan.size() && plan[ni]);
                ni++;
                if (!n) begin ok = 1; break; end
            end
            if (!ok) exp_err = 1;
        end
        for (int a = 0; a < DEPTH; a++) begin
            if (rom[a] == 16'hFFF0) lead++;
            else begin has_write = (rom[a] != 16'hFFFF); break; end
        end

        ready_wait = rw; lat = dl; nack_word = nw;
        nack_q = plan;
        obs_q.delete();
        fetches = 0; unstable = 0; low_ready = 0; id_bad = 0;
        pulse_start();
        while (!done && c < 3000) begin
            if (valid && first < 0) first = c;
            if (stray_en && c == 5) stray = 1;
            if (extra_start && c == 10) start = 1'b1;
            if (extra_start && c == 11) start = 1'b0;
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_nwrites"}, 32'(obs_q.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < obs_q.size(); i++)
            chk({tag, "_write"}, 32'(obs_q[i]), 32'(exp_w[i]));
        chk({tag, "_fetches"}, 32'(fetches), 32'(exp_fetch));
        chk({tag, "_addr"}, 32'(raddr), 32'(exp_fetch - 1));
        chk({tag, "_stable"}, 32'(unstable), 32'd0);
        chk({tag, "_lowready"}, 32'(low_ready), 32'(rw * exp_w.size()));
        chk({tag, "_id"}, 32'(id_bad), 32'd0);
        if (has_write) chk({tag, "_firstlat"}, 32'(first), 32'(3 + (DLY + 4) * lead));
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_id", 32'(id), 32'h42);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        rom = '{16'h1280, 16'h1101, 16'hFFFF, 16'h0000};
        plan.delete();
        run_pass("basic", 0, 5, -1, 0, 0);

        rom = '{16'hFFF0, 16'h3A04, 16'hFFFF, 16'h0000};
        run_pass("delay", 0, 3, -1, 1, 0);

        rom = '{16'h1280, 16'h1101, 16'hFFFF, 16'h0000};
        run_pass("readylow", 10, 2, -1, 0, 0);

        run_pass("nack", 0, 2, 32'h1280, 0, 0);

        // Reset while a write is in flight.
        rom = '{16'h1280, 16'h1101, 16'h3A04, 16'h1E07};
        ready_wait = 0; lat = 50; nack_word = -1; nack_q.delete(); obs_q.delete();
        pulse_start();
        for (int c = 0; c < 200 && obs_q.size() < 1; c++) @(negedge clk);
        chk("inflight_accept", 32'(obs_q.size()), 32'd1);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("arst_outs", {raddr, rden, valid, busy, done, err, rg, dt}, 32'd0);
        chk("arst_id", 32'(id), 32'h42);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("postrst_busy", 32'(busy), 32'd0);
        chk("postrst_valid", 32'(valid), 32'd0);
        run_pass("nomarker", 1, 50, -1, 0, 1);

        for (int p = 0; p < 12; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                int unsigned r;
                r = $urandom_range(0, 9);
                if (r < 2)       rom[a] = 16'hFFF0;
                else if (r == 2) rom[a] = 16'hFFFF;
                else begin
                    rom[a] = 16'($urandom);
                    if (rom[a][15:4] == 12'hFFF) rom[a][15] = 1'b0;
                end
            end
            plan.delete();
            for (int i = 0; i < 16; i++) plan.push_back($urandom_range(0, 9) < 3);
            run_pass($sformatf("rand%0d", p), int'($urandom_range(0, 3)),
                     int'($urandom_range(1, 6)), -1, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ov7670_cfg_seq.md
OV7670_CFG_SEQ -- requirements
Module: ov7670_cfg_seq

Interface
REQ-001 SHALL have parameter DEPTH, 101, number of entries in the register-init ROM.
REQ-002 SHALL have parameter LEN, $clog2(DEPTH), ROM address width.
REQ-003 SHALL have parameter DELAY_CYCLES, 1000000, clock cycles waited for a delay entry.
REQ-004 SHALL have parameter SCCB_ID, 8'h42, device write address driven on o_cfg_sccb_id.
REQ-005 SHALL have port i_cfg_clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port i_cfg_rstn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port i_cfg_start  input  1  single-cycle pulse starting a configuration pass.
REQ-008 SHALL have port o_cfg_rom_rden  output  1  ROM read enable.
REQ-009 SHALL have port o_cfg_rom_addr  output  LEN  ROM read address.
REQ-010 SHALL have port i_cfg_rom_data  input  16  ROM data, valid one cycle after rden; {reg[15:8], data[7:0]}.
REQ-011 SHALL have port o_cfg_sccb_valid  output  1  write request to SCCB master.
REQ-012 SHALL have port i_cfg_sccb_ready  input  1  SCCB master accepts request when high with valid.
REQ-013 SHALL have port o_cfg_sccb_id / o_cfg_sccb_reg / o_cfg_sccb_data  output  8 each  write payload.
REQ-014 SHALL have port i_cfg_sccb_done  input  1  pulse: accepted transaction finished.
REQ-015 SHALL have port i_cfg_sccb_nack  input  1  qualified by done: transaction was not acknowledged.
REQ-016 SHALL have ports o_cfg_busy, o_cfg_done, o_cfg_err  output  1 each  pass running / pass finished (sticky) / NACK seen (sticky).

Function
REQ-017 SHALL implement states IDLE, FETCH, ROMWAIT, DECODE, SEND, WAITDONE, DELAY, NEXT, FINISH.
REQ-018 IDLE: on i_cfg_start -> FETCH, address=0, o_cfg_done and o_cfg_err cleared; start ignored in all other states except FINISH.
REQ-019 FETCH: o_cfg_rom_rden high exactly one cycle with current address -> ROMWAIT; ROMWAIT -> DECODE (data sampled in DECODE).
REQ-020 DECODE: 16'hFFFF -> FINISH; 16'hFFF0 -> DELAY; otherwise latch reg/data -> SEND.
REQ-021 SEND: o_cfg_sccb_valid held high, payload stable, until the cycle valid&&ready; then valid low next cycle -> WAITDONE.
REQ-022 WAITDONE: on i_cfg_sccb_done -> NEXT; if i_cfg_sccb_nack also high, handle per REQ-030/031.
REQ-023 DELAY: counter counts DELAY_CYCLES cycles then -> NEXT; no SCCB activity.
REQ-024 NEXT: address+1; if new address == DEPTH -> FINISH else -> FETCH; address never wraps.
REQ-025 FINISH: o_cfg_done=1, o_cfg_busy=0; i_cfg_start restarts from address 0 (as REQ-018).
REQ-026 o_cfg_busy SHALL be 1 in every state except IDLE and FINISH.
REQ-027 o_cfg_sccb_id SHALL equal SCCB_ID constantly.
REQ-028 done pulses outside WAITDONE SHALL be ignored.

Reset
REQ-029 Asserting i_cfg_rstn low at any time SHALL immediately force IDLE, address 0, delay counter 0, and all outputs 0 (except o_cfg_sccb_id), abandoning any in-flight request; no pass starts until a new i_cfg_start.

Configuration
REQ-030 Macro OV7670_CFG_RETRY_EN defined: a NACKed write SHALL return to SEND with the same payload, up to 3 retries; after the 3rd retry NACK, set o_cfg_err and -> NEXT.
REQ-031 Macro undefined: any NACK SHALL set o_cfg_err and -> NEXT (no retry); sequence always continues.

Verification
REQ-032 ROM {0x1280, 0x1101, 0xFFFF}, ready=1, done 5 cycles after accept -> exactly 2 writes (0x12/0x80, 0x11/0x01), then done=1, busy=0, err=0.
REQ-033 ROM {0xFFF0, 0x3A04, 0xFFFF}, DELAY_CYCLES=20 -> no valid for 20 cycles after decode, then write 0x3A/0x04, done=1.
REQ-034 ready held low 10 cycles in SEND -> valid and payload stable all 10 cycles; single transaction after ready rises.
REQ-035 NACK on every attempt of 0x1280 -> without macro: 1 attempt, err=1; with OV7670_CFG_RETRY_EN: 4 attempts, err=1; next entry still written.
REQ-036 rstn low during WAITDONE, start pulse ignored while busy, no 0xFFFF in DEPTH=4 ROM -> reset clears all outputs; busy pass unaffected by extra start; pass ends after address 3 with done=1.
